// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the pipeline hazard logic.
//   FWD_* : operand-forward select values driven onto ForwardAE/ForwardBE
//   RES_* : ResultSrc encodings carried with each instruction
package riscv_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // operand from ResultW
    localparam logic [1:0] FWD_MEM = 2'b10;  // operand from ALUResultM

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;  // load: result only known after memory
    localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/hazard_forward_sel.sv
// hazard_forward_sel: priority forward selector for a single execute-stage operand.
// Ports:
//   i_rs_e          source register of the operand in execute
//   i_rd_m          destination register of the instruction in memory
//   i_reg_write_m   memory-stage instruction writes the register file
//   i_rd_w          destination register of the instruction in writeback
//   i_reg_write_w   writeback-stage instruction writes the register file
//   o_forward       FWD_MEM / FWD_WB / FWD_RF select
module hazard_forward_sel #(
    parameter int unsigned REG_W = 5
) (
    input  logic [REG_W-1:0] i_rs_e,
    input  logic [REG_W-1:0] i_rd_m,
    input  logic             i_reg_write_m,
    input  logic [REG_W-1:0] i_rd_w,
    input  logic             i_reg_write_w,
    output logic [1:0]       o_forward
);
    import riscv_pkg::*;

    logic w_hit_m;
    logic w_hit_w;

    // x0 is hard-wired to zero, so a write to it must never be forwarded.
    assign w_hit_m = i_reg_write_m && (i_rd_m != '0) && (i_rd_m == i_rs_e);
    assign w_hit_w = i_reg_write_w && (i_rd_w != '0) && (i_rd_w == i_rs_e);

    // Memory stage holds the younger result, so it wins over writeback.
    always_comb begin
        o_forward = FWD_RF;
        if (w_hit_m) begin
            o_forward = FWD_MEM;
        end else if (w_hit_w) begin
            o_forward = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding, load-use stall and taken-branch flush control.
// Shadows rd/write-enable/result-source of the E, M and W instructions and
// derives the control outputs combinationally from that state and the D inputs.
// Ports:
//   clock, reset                  clock and synchronous active-high reset
//   Rs1D, Rs2D, RdD               register indices of the decode instruction
//   RegWriteD, ResultSrcD         write enable / result source of decode instruction
//   PCSrcE                        taken branch/jump in execute
//   ForwardAE, ForwardBE          execute operand forward selects
//   StallF, StallD, FlushD, FlushE fetch/decode/execute pipeline control
//   stall_cycles, flush_events    saturating performance counters
module hazard_unit #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] RdD,
    input  logic             RegWriteD,
    input  logic [1:0]       ResultSrcD,
    input  logic             PCSrcE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);
    import riscv_pkg::*;

    // Shadow pipeline state
    logic [REG_W-1:0] r_rs1_e;
    logic [REG_W-1:0] r_rs2_e;
    logic [REG_W-1:0] r_rd_e;
    logic             r_reg_write_e;
    logic [1:0]       r_result_src_e;
    logic [REG_W-1:0] r_rd_m;
    logic             r_reg_write_m;
    logic [REG_W-1:0] r_rd_w;
    logic             r_reg_write_w;

    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    logic w_lw_stall;

    hazard_forward_sel #(
        .REG_W (REG_W)
    ) u_fwd_a (
        .i_rs_e        (r_rs1_e),
        .i_rd_m        (r_rd_m),
        .i_reg_write_m (r_reg_write_m),
        .i_rd_w        (r_rd_w),
        .i_reg_write_w (r_reg_write_w),
        .o_forward     (ForwardAE)
    );

    hazard_forward_sel #(
        .REG_W (REG_W)
    ) u_fwd_b (
        .i_rs_e        (r_rs2_e),
        .i_rd_m        (r_rd_m),
        .i_reg_write_m (r_reg_write_m),
        .i_rd_w        (r_rd_w),
        .i_reg_write_w (r_reg_write_w),
        .o_forward     (ForwardBE)
    );

    // A load in E cannot forward in time for a dependent instruction in D.
    assign w_lw_stall = (r_result_src_e == RES_MEM) && r_reg_write_e && (r_rd_e != '0) &&
                        ((r_rd_e == Rs1D) || (r_rd_e == Rs2D));

    // A taken redirect squashes the dependent instruction anyway, so it overrides the stall.
    assign StallF = w_lw_stall && !PCSrcE;
    assign StallD = StallF;
    assign FlushD = PCSrcE;
    assign FlushE = w_lw_stall || PCSrcE;

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rs1_e        <= '0;
            r_rs2_e        <= '0;
            r_rd_e         <= '0;
            r_reg_write_e  <= 1'b0;
            r_result_src_e <= RES_ALU;
            r_rd_m         <= '0;
            r_reg_write_m  <= 1'b0;
            r_rd_w         <= '0;
            r_reg_write_w  <= 1'b0;
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            r_rd_w        <= r_rd_m;
            r_reg_write_w <= r_reg_write_m;
            r_rd_m        <= r_rd_e;
            r_reg_write_m <= r_reg_write_e;
            if (FlushE) begin
                // Bubble: never writes, never matches as a producer.
                r_rs1_e        <= '0;
                r_rs2_e        <= '0;
                r_rd_e         <= '0;
                r_reg_write_e  <= 1'b0;
                r_result_src_e <= RES_ALU;
            end else begin
                r_rs1_e        <= Rs1D;
                r_rs2_e        <= Rs2D;
                r_rd_e         <= RdD;
                r_reg_write_e  <= RegWriteD;
                r_result_src_e <= ResultSrcD;
            end
            if (StallF && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (PCSrcE && (r_flush_events != {CNT_W{1'b1}})) begin
                r_flush_events <= r_flush_events + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed plus randomized checks of hazard_unit against a
// stage-list reference model. A second instance with 4-bit counters covers saturation.
module tb_hazard_unit;

    logic       clock;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, RdD;
    logic       RegWriteD;
    logic [1:0] ResultSrcD;
    logic       PCSrcE;

    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, FlushD, FlushE;
    logic [31:0] stall_cycles, flush_events;

    logic [1:0] s_fa, s_fb;
    logic       s_sf, s_sd, s_fd, s_fe;
    logic [3:0] s_stall, s_flush;

    int checks = 0;
    int errors = 0;

    hazard_unit #(.REG_W(5), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .FlushE(FlushE), .stall_cycles(stall_cycles),
        .flush_events(flush_events)
    );

    hazard_unit #(.REG_W(5), .CNT_W(4)) dut_small (
        .clock(clock), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE),
        .ForwardAE(s_fa), .ForwardBE(s_fb), .StallF(s_sf), .StallD(s_sd),
        .FlushD(s_fd), .FlushE(s_fe), .stall_cycles(s_stall), .flush_events(s_flush)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: a list of in-flight instructions, index 0 = E, 1 = M, 2 = W.
    typedef struct {
        int rs1;
        int rs2;
        int rd;
        bit wr;
        int src;
    } instr_t;

    instr_t      pipe[3];
    longint      m_stall, m_flush;
    const longint MAX32 = 64'hFFFF_FFFF;

    function automatic int writes_reg(instr_t x);
        return (x.wr && x.rd != 0) ? 1 : 0;
    endfunction

    function automatic int exp_fwd(int rs);
        if (writes_reg(pipe[1]) && pipe[1].rd == rs) return 2;
        if (writes_reg(pipe[2]) && pipe[2].rd == rs) return 1;
        return 0;
    endfunction

    function automatic bit exp_lw();
        return pipe[0].src == 1 && writes_reg(pipe[0]) == 1 &&
               (pipe[0].rd == int'(Rs1D) || pipe[0].rd == int'(Rs2D));
    endfunction

    function automatic longint sat(longint v, longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit lw, br;
        lw = exp_lw();
        br = PCSrcE;
        chk("ForwardAE", {30'd0, ForwardAE}, exp_fwd(pipe[0].rs1));
        chk("ForwardBE", {30'd0, ForwardBE}, exp_fwd(pipe[0].rs2));
        chk("StallF", {31'd0, StallF}, {31'd0, lw && !br});
        chk("StallD", {31'd0, StallD}, {31'd0, lw && !br});
        chk("FlushD", {31'd0, FlushD}, {31'd0, br});
        chk("FlushE", {31'd0, FlushE}, {31'd0, lw || br});
        chk("stall_cycles", stall_cycles, m_stall[31:0]);
        chk("flush_events", flush_events, m_flush[31:0]);
        chk("stall_cycles_w4", {28'd0, s_stall}, sat(m_stall, 15));
        chk("flush_events_w4", {28'd0, s_flush}, sat(m_flush, 15));
    endtask

    task automatic drive(input int rs1, input int rs2, input int rd, input bit wr,
                         input int src, input bit br, input bit rst);
        Rs1D       = 5'(rs1);
        Rs2D       = 5'(rs2);
        RdD        = 5'(rd);
        RegWriteD  = wr;
        ResultSrcD = 2'(src);
        PCSrcE     = br;
        reset      = rst;
        #1;
    endtask

    task automatic step(input int rs1, input int rs2, input int rd, input bit wr,
                        input int src, input bit br, input bit rst);
        drive(rs1, rs2, rd, wr, src, br, rst);
        check_all();
    endtask

    // Advance model and DUT by one rising edge using the inputs currently applied.
    task automatic tick();
        instr_t nop, d;
        bit lw;
        nop = '{0, 0, 0, 1'b0, 0};
        d   = '{int'(Rs1D), int'(Rs2D), int'(RdD), RegWriteD, int'(ResultSrcD)};
        if (reset) begin
            pipe    = '{nop, nop, nop};
            m_stall = 0;
            m_flush = 0;
        end else begin
            lw = exp_lw();
            if (lw && !PCSrcE) m_stall = sat(m_stall + 1, MAX32);
            if (PCSrcE)        m_flush = sat(m_flush + 1, MAX32);
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (lw || PCSrcE) ? nop : d;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    longint base_stall, base_flush;

    initial begin
        // Reset (DUT state is unknown before the first reset edge, so no check yet).
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        step(0, 0, 0, 0, 0, 0, 0);
        chk("rst_fwdA", {30'd0, ForwardAE}, 0);
        chk("rst_stallF", {31'd0, StallF}, 0);
        chk("rst_cnt", stall_cycles, 0);

        // ALU chain, back to back: x5 = ..., then reads x5 -> forward from M.
        tick();
        step(0, 0, 5, 1, 0, 0, 0); tick();
        step(5, 1, 6, 1, 0, 0, 0); tick();
        step(0, 0, 0, 0, 0, 0, 0);
        chk("alu_fwdA_mem", {30'd0, ForwardAE}, 2);
        tick();
        // ALU chain with one unrelated instruction between -> forward from W.
        step(0, 0, 5, 1, 0, 0, 0); tick();
        step(2, 3, 4, 1, 0, 0, 0); tick();
        step(5, 1, 6, 1, 0, 0, 0); tick();
        step(0, 0, 0, 0, 0, 0, 0);
        chk("alu_fwdA_wb", {30'd0, ForwardAE}, 1);
        tick();

        // Double hazard on x7: M has priority.
        step(0, 0, 7, 1, 0, 0, 0); tick();
        step(0, 0, 7, 1, 0, 0, 0); tick();
        step(1, 7, 8, 1, 0, 0, 0); tick();
        step(0, 0, 0, 0, 0, 0, 0);
        chk("double_fwdB", {30'd0, ForwardBE}, 2);
        tick();

        // Writes to x0 are never forwarded.
        step(0, 0, 0, 1, 0, 0, 0); tick();
        step(0, 0, 3, 1, 0, 0, 0); tick();
        step(0, 0, 0, 0, 0, 0, 0);
        chk("x0_fwdA", {30'd0, ForwardAE}, 0);
        chk("x0_fwdB", {30'd0, ForwardBE}, 0);
        tick();

        // Load-use: lw x9 then add using x9.
        base_stall = m_stall;
        step(0, 0, 9, 1, 1, 0, 0); tick();
        step(9, 2, 10, 1, 0, 0, 0);
        chk("lu_stallF", {31'd0, StallF}, 1);
        chk("lu_flushE", {31'd0, FlushE}, 1);
        tick();
        step(9, 2, 10, 1, 0, 0, 0);
        chk("lu_stall_once", {31'd0, StallF}, 0);
        chk("lu_cnt", stall_cycles, 32'(base_stall + 1));
        tick();
        step(0, 0, 0, 0, 0, 0, 0);
        chk("lu_fwdA_wb", {30'd0, ForwardAE}, 1);
        tick();

        // Taken branch, then taken branch coinciding with a load-use hazard.
        base_flush = m_flush;
        step(1, 2, 3, 1, 0, 1, 0);
        chk("br_flushD", {31'd0, FlushD}, 1);
        chk("br_stallF", {31'd0, StallF}, 0);
        tick();
        step(0, 0, 0, 0, 0, 0, 0);
        chk("br_cnt", flush_events, 32'(base_flush + 1));
        tick();
        step(0, 0, 11, 1, 1, 0, 0); tick();
        step(11, 0, 12, 1, 0, 1, 0);
        chk("brlu_stallF", {31'd0, StallF}, 0);
        chk("brlu_flushD", {31'd0, FlushD}, 1);
        chk("brlu_flushE", {31'd0, FlushE}, 1);
        tick();

        // Reset asserted in the stall cycle.
        step(0, 0, 13, 1, 1, 0, 0); tick();
        step(13, 0, 14, 1, 0, 0, 1);
        chk("rstst_stallF", {31'd0, StallF}, 1);
        tick();
        step(13, 0, 14, 1, 0, 0, 0);
        chk("rstst_stallF_after", {31'd0, StallF}, 0);
        chk("rstst_flushE_after", {31'd0, FlushE}, 0);
        chk("rstst_cnt", stall_cycles, 0);
        tick();

        // 20 load-use stalls: the 4-bit counter must stop at 15.
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 9, 1, 1, 0, 0); tick();
            step(9, 0, 10, 1, 0, 0, 0); tick();
        end
        step(0, 0, 0, 0, 0, 0, 0);
        chk("sat_w4", {28'd0, s_stall}, 15);
        chk("sat_w32", stall_cycles, 20);
        tick();

        // Randomized traffic over a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                 1'($urandom_range(0, 3) != 0), $urandom_range(0, 2),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 60) == 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
